// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle between decode/execute and the scoreboarded
//               register file: two read ports, one writeback port, a mark
//               port for multi-cycle producers and the pending status.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
);
    logic [REGBITS-1:0] ra1;
    logic [REGBITS-1:0] ra2;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic               busy1;
    logic               busy2;
    logic               stall;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic               mark;
    logic [REGBITS-1:0] ma;
    logic [REGBITS-1:0] npend;

    // Pipeline side: drives addresses, writeback and mark; observes data/status
    modport master (
        output ra1, ra2, regwrite, wa, wd, mark, ma,
        input  rd1, rd2, busy1, busy2, stall, npend
    );

    // Register-file side
    modport slave (
        input  ra1, ra2, regwrite, wa, wd, mark, ma,
        output rd1, rd2, busy1, busy2, stall, npend
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file (r0 hardwired to zero) with a
//               per-register pending scoreboard, combinational read ports,
//               stall generation and a registered pending count.
//               Optional feature macro: REGFILE_BYPASS_EN (write-to-read
//               bypass of data and busy on a same-cycle writeback).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  wire         clk,
    input  wire         reset,
    regfile_sb_if.slave bus
);

    localparam int c_DEPTH = 1 << REGBITS;

    logic [WIDTH-1:0]   r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;
    logic [REGBITS-1:0] r_npend;

    logic [c_DEPTH-1:0] w_pend_nxt;
    logic [REGBITS-1:0] w_cnt;
    logic [WIDTH-1:0]   w_rd1;
    logic [WIDTH-1:0]   w_rd2;
    logic               w_busy1;
    logic               w_busy2;

    // Next-state pending vector: writeback clears, mark sets (newer producer
    // wins on a collision), reset clears everything. r0 is never touched.
    always_comb begin
        w_pend_nxt = r_pend;
        if (bus.regwrite && (bus.wa != '0)) begin
            w_pend_nxt[bus.wa] = 1'b0;
        end
        if (bus.mark && (bus.ma != '0)) begin
            w_pend_nxt[bus.ma] = 1'b1;
        end
        if (reset) begin
            w_pend_nxt = '0;
        end
    end

    // Population count of the next-state pending bits; bit 0 is always clear,
    // so the maximum (2^REGBITS - 1) fits in REGBITS bits.
    always_comb begin
        w_cnt = '0;
        for (int i = 1; i < c_DEPTH; i++) begin
            w_cnt = w_cnt + REGBITS'(w_pend_nxt[i]);
        end
    end

    // Register array storage; r0 is held at zero and never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.regwrite && (bus.wa != '0)) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // Scoreboard state and registered pending count
    always_ff @(posedge clk) begin
        r_pend  <= w_pend_nxt;
        r_npend <= w_cnt;
    end

    // Read port 1: array read, optionally overridden by a same-cycle writeback
    always_comb begin
        w_rd1   = (bus.ra1 != '0) ? r_regs[bus.ra1] : '0;
        w_busy1 = (bus.ra1 != '0) && r_pend[bus.ra1];
`ifdef REGFILE_BYPASS_EN
        if (bus.regwrite && (bus.wa != '0) && (bus.wa == bus.ra1)) begin
            w_rd1   = bus.wd;
            w_busy1 = 1'b0;
        end
`else
`endif
    end

    // Read port 2: same structure as port 1
    always_comb begin
        w_rd2   = (bus.ra2 != '0) ? r_regs[bus.ra2] : '0;
        w_busy2 = (bus.ra2 != '0) && r_pend[bus.ra2];
`ifdef REGFILE_BYPASS_EN
        if (bus.regwrite && (bus.wa != '0) && (bus.wa == bus.ra2)) begin
            w_rd2   = bus.wd;
            w_busy2 = 1'b0;
        end
`else
`endif
    end

    // Stall depends only on current state and writeback, never on mark/ma
    assign bus.rd1   = w_rd1;
    assign bus.rd2   = w_rd2;
    assign bus.busy1 = w_busy1;
    assign bus.busy2 = w_busy2;
    assign bus.stall = w_busy1 | w_busy2;
    assign bus.npend = r_npend;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench for regfile_sb. The driver pushes the
//               hand-computed expected outputs for each cycle; a separate
//               monitor pops and compares them on the falling edge.
//               Two instances: WIDTH=8/REGBITS=3 and WIDTH=16/REGBITS=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk;
    logic reset;

    regfile_sb_if #(.WIDTH(8),  .REGBITS(3)) bus_a ();
    regfile_sb_if #(.WIDTH(16), .REGBITS(5)) bus_b ();

    regfile_sb #(.WIDTH(8), .REGBITS(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    regfile_sb #(.WIDTH(16), .REGBITS(5)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field mask bits
    localparam logic [5:0] c_M_RD1 = 6'b000001;
    localparam logic [5:0] c_M_RD2 = 6'b000010;
    localparam logic [5:0] c_M_B1  = 6'b000100;
    localparam logic [5:0] c_M_B2  = 6'b001000;
    localparam logic [5:0] c_M_ST  = 6'b010000;
    localparam logic [5:0] c_M_NP  = 6'b100000;

    typedef struct {
        string       name;
        bit          dut;
        logic [5:0]  mask;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        b1;
        logic        b2;
        logic        st;
        logic [4:0]  np;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    task automatic expect_out(input string name, input bit dut, input logic [5:0] mask,
                              input logic [15:0] rd1, input logic [15:0] rd2,
                              input logic b1, input logic b2, input logic st,
                              input logic [4:0] np);
        exp_t e;
        e.name = name; e.dut = dut; e.mask = mask;
        e.rd1 = rd1; e.rd2 = rd2; e.b1 = b1; e.b2 = b2; e.st = st; e.np = np;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, exp);
        end
    endtask

    // Monitor: compare every pending expectation against the DUT outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] rd1, rd2;
            logic b1, b2, st;
            logic [4:0] np;
            e = sb.pop_front();
            if (e.dut) begin
                rd1 = bus_b.rd1; rd2 = bus_b.rd2; b1 = bus_b.busy1; b2 = bus_b.busy2;
                st = bus_b.stall; np = bus_b.npend;
            end else begin
                rd1 = {8'h00, bus_a.rd1}; rd2 = {8'h00, bus_a.rd2};
                b1 = bus_a.busy1; b2 = bus_a.busy2; st = bus_a.stall;
                np = {2'b00, bus_a.npend};
            end
            if (e.mask[0]) cmp(e.name, "rd1",   rd1, e.rd1);
            if (e.mask[1]) cmp(e.name, "rd2",   rd2, e.rd2);
            if (e.mask[2]) cmp(e.name, "busy1", {15'd0, b1}, {15'd0, e.b1});
            if (e.mask[3]) cmp(e.name, "busy2", {15'd0, b2}, {15'd0, e.b2});
            if (e.mask[4]) cmp(e.name, "stall", {15'd0, st}, {15'd0, e.st});
            if (e.mask[5]) cmp(e.name, "npend", {11'd0, np}, {11'd0, e.np});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.regwrite = 1'b0; bus_a.wa = '0; bus_a.wd = '0;
        bus_a.mark = 1'b0; bus_a.ma = '0;
    endtask

    task automatic idle_b();
        bus_b.regwrite = 1'b0; bus_b.wa = '0; bus_b.wd = '0;
        bus_b.mark = 1'b0; bus_b.ma = '0;
    endtask

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    localparam logic [5:0] c_M_ALL = 6'b111111;

    initial begin
        reset = 1'b1;
        idle_a(); idle_b();
        bus_a.ra1 = '0; bus_a.ra2 = '0;
        bus_b.ra1 = '0; bus_b.ra2 = '0;
        step();
        step();
        reset = 1'b0;

        // Post-reset: every address reads zero, nothing pending
        for (int a = 0; a < 8; a++) begin
            bus_a.ra1 = 3'(a);
            bus_a.ra2 = 3'(7 - a);
            expect_out("reset_read", 1'b0, c_M_ALL, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
            step();
        end

        // Write A5 to r3; bypass shows it the same cycle
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd3; bus_a.wd = 8'hA5;
        bus_a.ra1 = 3'd3; bus_a.ra2 = 3'd0;
        expect_out("wr_r3_same", 1'b0, c_M_RD1 | c_M_B1 | c_M_NP,
                   c_BYP ? 16'h00A5 : 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        idle_a();
        expect_out("wr_r3_next", 1'b0, c_M_RD1 | c_M_ST | c_M_NP,
                   16'h00A5, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();

        // r0 ignores writes and marks
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd0; bus_a.wd = 8'hFF;
        bus_a.mark = 1'b1; bus_a.ma = 3'd0; bus_a.ra1 = 3'd0;
        expect_out("r0_same", 1'b0, c_M_RD1 | c_M_B1 | c_M_NP,
                   16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        idle_a();
        expect_out("r0_next", 1'b0, c_M_RD1 | c_M_B1 | c_M_ST | c_M_NP,
                   16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();

        // Mark r5: no busy in the mark cycle
        bus_a.mark = 1'b1; bus_a.ma = 3'd5; bus_a.ra1 = 3'd5; bus_a.ra2 = 3'd6;
        expect_out("mark5_same", 1'b0, c_M_B1 | c_M_ST | c_M_NP,
                   16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        bus_a.ma = 3'd6;
        expect_out("mark6_same", 1'b0, c_M_B1 | c_M_B2 | c_M_ST | c_M_NP,
                   16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 5'd1);
        step();
        idle_a();
        expect_out("both_busy", 1'b0, c_M_ALL,
                   16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 5'd2);
        step();

        // Writeback to r5 releases the read (same cycle with bypass)
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd5; bus_a.wd = 8'h11;
        expect_out("wb5_same", 1'b0, c_M_ALL,
                   c_BYP ? 16'h0011 : 16'h0000, 16'h0, !c_BYP, 1'b1, 1'b1, 5'd2);
        step();
        idle_a();
        expect_out("wb5_next", 1'b0, c_M_ALL,
                   16'h0011, 16'h0, 1'b0, 1'b1, 1'b1, 5'd1);
        step();

        // Writeback to r6 through read port 2
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd6; bus_a.wd = 8'h22;
        bus_a.ra1 = 3'd0;
        expect_out("wb6_same", 1'b0, c_M_RD2 | c_M_B2 | c_M_ST | c_M_NP,
                   16'h0, c_BYP ? 16'h0022 : 16'h0000, 1'b0, !c_BYP, !c_BYP, 5'd1);
        step();
        idle_a();
        expect_out("wb6_next", 1'b0, c_M_ALL,
                   16'h0, 16'h0022, 1'b0, 1'b0, 1'b0, 5'd0);
        step();

        // Same-cycle mark and write of r2: data stored, pending set
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd2; bus_a.wd = 8'h3C;
        bus_a.mark = 1'b1; bus_a.ma = 3'd2; bus_a.ra1 = 3'd2; bus_a.ra2 = 3'd0;
        expect_out("mw2_same", 1'b0, c_M_RD1 | c_M_B1 | c_M_ST | c_M_NP,
                   c_BYP ? 16'h003C : 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        idle_a();
        expect_out("mw2_next", 1'b0, c_M_RD1 | c_M_B1 | c_M_ST | c_M_NP,
                   16'h003C, 16'h0, 1'b1, 1'b0, 1'b1, 5'd1);
        step();

        // Mark r1..r7 (r2 already pending): count saturates at 7 without wrap
        for (int k = 1; k < 8; k++) begin
            bus_a.mark = 1'b1; bus_a.ma = 3'(k);
            step();
        end
        idle_a();
        bus_a.ra1 = 3'd7; bus_a.ra2 = 3'd1;
        expect_out("all_marked", 1'b0, c_M_B1 | c_M_B2 | c_M_ST | c_M_NP,
                   16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 5'd7);
        step();

        // Reset dominates a simultaneous writeback to r4
        reset = 1'b1;
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd4; bus_a.wd = 8'h77;
        bus_a.ra1 = 3'd4; bus_a.ra2 = 3'd3;
        expect_out("rst_cycle", 1'b0, c_M_NP, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd7);
        step();
        reset = 1'b0;
        idle_a();
        expect_out("after_rst", 1'b0, c_M_ALL,
                   16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();

        // Writeback after reset is a plain write
        bus_a.regwrite = 1'b1; bus_a.wa = 3'd4; bus_a.wd = 8'h5A;
        step();
        idle_a();
        expect_out("post_rst_wr", 1'b0, c_M_RD1 | c_M_B1 | c_M_NP,
                   16'h005A, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();

        // Wide/deep instance: r31 read-back and r17 stall
        bus_b.regwrite = 1'b1; bus_b.wa = 5'd31; bus_b.wd = 16'hBEEF;
        step();
        idle_b();
        bus_b.ra1 = 5'd31;
        expect_out("b_r31", 1'b1, c_M_RD1 | c_M_B1 | c_M_NP,
                   16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        bus_b.mark = 1'b1; bus_b.ma = 5'd17; bus_b.ra2 = 5'd17;
        expect_out("b_mark17_same", 1'b1, c_M_B2 | c_M_ST,
                   16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        idle_b();
        expect_out("b_mark17_next", 1'b1, c_M_B2 | c_M_ST | c_M_NP,
                   16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 5'd1);
        step();

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 entries left", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
